snow3g_f8_xor: RTL and testbench
================================

// Module: snow3g_f8_xor
// PURPOSE
//  Consumer end of the SNOW 3G keystream interface: accepts 32-bit keystream words z
//  from the Keystream generator and XORs them onto a 32-bit data stream (f8-style cipher).
//  Sits between the Keystream core and the data path; the same block encrypts and decrypts.
//  Prefetches keystream into a small FIFO. Emits exactly ceil(len_bits/32) output words.
// PARAMETERS
//  W           32  data/keystream word width (fixed 32 for SNOW 3G)
//  FIFO_DEPTH  4   keystream prefetch FIFO entries (power of 2, >=2)
//  LEN_W       16  width of message length in bits
// PORTS
//  clk        in   1      clock, all logic rising-edge
//  rst        in   1      synchronous reset, active-low (rst==0 resets on clk edge)
//  start      in   1      1-cycle pulse: begin message; sampled only in IDLE
//  len_bits   in   LEN_W  message length in bits, captured with start
//  busy       out  1      high from cycle after accepted start until DONE
//  done       out  1      1-cycle pulse after last output word accepted
//  ks_valid   in   1      keystream word available
//  ks_word    in   W      keystream word z (MSB = first keystream bit)
//  ks_ready   out  1      keystream word accepted when ks_valid&ks_ready
//  din_valid  in   1      data word available
//  din        in   W      plaintext/ciphertext word, MSB first
//  din_ready  out  1      data word accepted when din_valid&din_ready
//  dout_valid out  1      output word valid (registered)
//  dout       out  W      din ^ ks_word (tail-masked, see CONFIGURATION)
//  dout_last  out  1      qualifies final output word of message
//  dout_ready in   1      downstream accepts when dout_valid&dout_ready
// BEHAVIOUR
//  Reset (rst=0): state IDLE; FIFO empty; counters 0; busy, done, ks_ready, din_ready,
//   dout_valid, dout_last = 0; dout = 0. Reset mid-message discards all state and FIFO.
//  nwords = (len_bits+31)>>5 (LEN_W+1-bit math, no overflow); rem = len_bits[4:0].
//  FSM: IDLE -start&len!=0-> RUN; IDLE -start&len==0-> DONE; RUN -last word accepted
//   downstream-> DONE; DONE -> IDLE (done=1 for this one cycle). start outside IDLE ignored.
//  ks_ready = RUN & FIFO not full & ks_fetched < nwords; never over-fetches past message.
//  Join: a word fires when FIFO non-empty & din_valid & (!dout_valid | dout_ready);
//   din_ready equals that condition minus din_valid term; pop FIFO and load output reg
//   same cycle. Latency din accept -> dout_valid: 1 cycle. Full throughput 1 word/clk.
//  dout held stable while dout_valid & !dout_ready. dout_last=1 on word index nwords-1.
//  Simultaneous FIFO push & pop when full-minus-0: pop frees slot only next cycle
//   (ks_ready uses registered count). Push & pop while empty not bypassed.
//  Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
//  Keystream left in FIFO at DONE is impossible by construction (fetched == nwords).
// CONFIGURATION
//  SNOW3G_TAIL_MASK_EN defined: if rem!=0, last dout keeps top rem bits, low 32-rem bits
//   forced 0 (mask = ~(32'hFFFFFFFF >> rem)). Undefined: last word fully XORed, no mask.
// STRUCTURE
//  Package snow3g_pkg: W constant, state enum {IDLE,RUN,DONE}, tail-mask function.
//  One sub-module: snow3g_ks_fifo (sync FIFO, push/pop/full/empty/count).
//  Top holds FSM, counters (ks_fetched, words_out), join and output register.
// TESTING
//  len=64, ks=FFFFFFFF,0F0F0F0F, din=12345678,AAAAAAAA, dout_ready=1 -> dout=EDCBA987,
//   A5A5A5A5; dout_last on 2nd; done 1 cycle later; ks_ready total 2 handshakes.
//  len=40, ks=0,FFFFFFFF, din=0,0 -> 2nd dout=FF000000 with TAIL_MASK_EN, FFFFFFFF without.
//  len=0 start -> no ks_ready/din_ready ever; done pulses 2 cycles after start; busy 1 cyc.
//  len=256, dout_ready toggled 1010.., ks_valid stalled 3 cycles -> 8 words, dout stable in
//   stalls, FIFO count never >FIFO_DEPTH, exactly 8 ks handshakes.
//  rst=0 asserted mid-message (after word 3 of 8) -> next cycle all outputs 0, IDLE; new
//   start len=32 completes normally with fresh keystream.
//  start pulsed again while busy -> ignored; nwords unchanged, single done.

Source files
------------

// File: rtl/snow3g_pkg.sv
// Shared definitions for the SNOW 3G f8 keystream/data XOR block.
// Contents: the fixed word width, the control FSM state type and the
// helper that builds the keep-mask for a partial final word.
package snow3g_pkg;

    localparam int W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Keep the top 'rem' bits of a word and clear the rest; rem == 0 means
    // the message ends on a word boundary, so the whole word is kept.
    function automatic logic [W-1:0] tail_mask(input logic [4:0] rem);
        logic [W-1:0] mask_v;
        if (rem == 5'd0) begin
            mask_v = {W{1'b1}};
        end else begin
            mask_v = ~({W{1'b1}} >> rem);
        end
        return mask_v;
    endfunction

endpackage

// File: rtl/snow3g_f8_xor_if.sv
// Bus bundle between a message source/sink and snow3g_f8_xor.
// Groups the message control (start, len_bits, busy, done), the keystream
// input channel (ks_*), the data input channel (din*) and the output
// channel (dout*).
//   master : the environment side (drives start, data, keystream, dout_ready)
//   slave  : the snow3g_f8_xor side
interface snow3g_f8_xor_if #(
    parameter int LEN_W = 16
) ();
    import snow3g_pkg::*;

    logic             start;
    logic [LEN_W-1:0] len_bits;
    logic             busy;
    logic             done;
    logic             ks_valid;
    logic [W-1:0]     ks_word;
    logic             ks_ready;
    logic             din_valid;
    logic [W-1:0]     din;
    logic             din_ready;
    logic             dout_valid;
    logic [W-1:0]     dout;
    logic             dout_last;
    logic             dout_ready;

    modport master (
        output start, len_bits, ks_valid, ks_word, din_valid, din, dout_ready,
        input  busy, done, ks_ready, din_ready, dout_valid, dout, dout_last
    );

    modport slave (
        input  start, len_bits, ks_valid, ks_word, din_valid, din, dout_ready,
        output busy, done, ks_ready, din_ready, dout_valid, dout, dout_last
    );

endinterface

// File: rtl/snow3g_ks_fifo.sv
// Small synchronous FIFO holding prefetched keystream words.
// Ports:
//   clk, rst      clock and synchronous active-low reset
//   push, wdata   write a word (ignored while full)
//   pop           drop the head word (ignored while empty)
//   rdata         head word, valid while !empty
//   full, empty   occupancy flags derived from the registered count
// A push and a pop in the same cycle are both honoured; a push into an
// empty FIFO becomes visible on rdata only from the next cycle.
module snow3g_ks_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Qualify requests against the registered occupancy
    always_comb begin
        push_ok_s = push && (count_r != CW'(DEPTH));
        pop_ok_s  = pop && (count_r != CW'(0));
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == CW'(0));

endmodule

// File: rtl/snow3g_f8_xor.sv
// SNOW 3G f8 data path: XORs 32-bit keystream words onto a 32-bit data
// stream. The same block encrypts and decrypts. Keystream is prefetched
// into a small FIFO, never beyond the number of words in the message, and
// exactly ceil(len_bits/32) output words are produced.
// Ports:
//   clk, rst   clock and synchronous active-low reset
//   bus        snow3g_f8_xor_if.slave:
//                start/len_bits  begin a message (sampled only when idle)
//                busy/done       message in progress / one-cycle completion
//                ks_*            keystream input channel (valid/ready)
//                din*            data input channel (valid/ready)
//                dout*           registered output channel, dout_last marks
//                                the final word
// Build option: define SNOW3G_TAIL_MASK_EN to clear the unused low bits of
// a partial final word; without it the final word is XORed in full.
module snow3g_f8_xor
    import snow3g_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    snow3g_f8_xor_if.slave bus
);
    // One extra bit so (len_bits + 31) cannot overflow
    localparam int CNT_W = LEN_W + 1;

    state_e           state_r;
    state_e           state_next_s;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] nwords_r;
    logic [CNT_W-1:0] ks_fetched_r;
    logic [CNT_W-1:0] words_out_r;
    logic [CNT_W-1:0] nwords_calc_s;
`ifdef SNOW3G_TAIL_MASK_EN
    logic [4:0]       rem_r;
`endif
    logic             start_accept_s;
    logic             ks_ready_s;
    logic             ks_push_s;
    logic             out_free_s;
    logic             din_ready_s;
    logic             fire_s;
    logic             last_word_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [W-1:0]     fifo_rdata_s;
    logic [W-1:0]     dout_next_s;
    logic [W-1:0]     dout_r;
    logic             dout_valid_r;
    logic             dout_last_r;

    snow3g_ks_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (W)
    ) u_ks_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ks_push_s),
        .wdata (bus.ks_word),
        .pop   (fire_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Handshake, join and output-word computation
    always_comb begin
        start_accept_s = (state_r == IDLE) && bus.start;
        nwords_calc_s  = ({1'b0, bus.len_bits} + CNT_W'(31)) >> 3'd5;
        // Fetch limit uses the registered fill level, so a slot freed by a
        // pop this cycle is only reused next cycle.
        ks_ready_s     = (state_r == RUN) && !fifo_full_s && (ks_fetched_r < nwords_r);
        ks_push_s      = ks_ready_s && bus.ks_valid;
        out_free_s     = !dout_valid_r || bus.dout_ready;
        din_ready_s    = (state_r == RUN) && !fifo_empty_s && out_free_s;
        fire_s         = din_ready_s && bus.din_valid;
        last_word_s    = (words_out_r == (nwords_r - CNT_W'(1)));
`ifdef SNOW3G_TAIL_MASK_EN
        dout_next_s    = (bus.din ^ fifo_rdata_s) &
                         (last_word_s ? tail_mask(rem_r) : {W{1'b1}});
`else
        dout_next_s    = bus.din ^ fifo_rdata_s;
`endif
    end

    // Next-state logic for the message FSM
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len_bits == {LEN_W{1'b0}}) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (dout_valid_r && bus.dout_ready && dout_last_r) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register; busy/done are registered from the next state so they
    // line up exactly with the state they describe
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Message length capture and fetch/output word counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            nwords_r     <= CNT_W'(0);
            ks_fetched_r <= CNT_W'(0);
            words_out_r  <= CNT_W'(0);
`ifdef SNOW3G_TAIL_MASK_EN
            rem_r        <= 5'd0;
`endif
        end else if (start_accept_s) begin
            nwords_r     <= nwords_calc_s;
            ks_fetched_r <= CNT_W'(0);
            words_out_r  <= CNT_W'(0);
`ifdef SNOW3G_TAIL_MASK_EN
            rem_r        <= bus.len_bits[4:0];
`endif
        end else begin
            if (ks_push_s) begin
                ks_fetched_r <= ks_fetched_r + CNT_W'(1);
            end
            if (fire_s) begin
                words_out_r <= words_out_r + CNT_W'(1);
            end
        end
    end

    // Output register: loads on a join, holds while stalled downstream
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_r       <= {W{1'b0}};
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
        end else if (fire_s) begin
            dout_r       <= dout_next_s;
            dout_valid_r <= 1'b1;
            dout_last_r  <= last_word_s;
        end else if (bus.dout_ready) begin
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.ks_ready   = ks_ready_s;
    assign bus.din_ready  = din_ready_s;
    assign bus.dout_valid = dout_valid_r;
    assign bus.dout       = dout_r;
    assign bus.dout_last  = dout_last_r;

endmodule

// File: tb/tb_snow3g_f8_xor.sv
// Self-checking bench for snow3g_f8_xor. Expected output words come from a
// reference model: word i = din[i] XOR ks[i], with the final partial word
// trimmed to its top (len mod 32) bits when SNOW3G_TAIL_MASK_EN is defined.
module tb_snow3g_f8_xor;

    logic clk = 1'b0;
    logic rst = 1'b0;

    snow3g_f8_xor_if #(.LEN_W(16)) bus ();

    snow3g_f8_xor #(
        .FIFO_DEPTH (4),
        .LEN_W      (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] ks_a  [64];
    logic [31:0] din_a [64];

    // Observations collected by the monitor
    logic [31:0] got_q [$];
    logic        got_last_q [$];
    int          ks_hs = 0, din_hs = 0, done_cnt = 0, busy_cnt = 0, stab_err = 0;
    int          cyc_ctr = 0, start_cyc = 0, done_cyc = 0, last_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dout = 32'd0;

    // Per-message baselines and FIFO occupancy high-water mark
    int ks_base, din_base, got_base, done_base, busy_base, stab_base, max_occ;

    // Handshake monitor sampling at the active edge
    always @(posedge clk) begin
        cyc_ctr <= cyc_ctr + 1;
        if (!rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (bus.ks_valid && bus.ks_ready) ks_hs <= ks_hs + 1;
            if (bus.din_valid && bus.din_ready) din_hs <= din_hs + 1;
            if (bus.dout_valid && bus.dout_ready) begin
                got_q.push_back(bus.dout);
                got_last_q.push_back(bus.dout_last);
                if (bus.dout_last) last_cyc <= cyc_ctr;
            end
            if (bus.done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc_ctr;
            end
            if (bus.busy) busy_cnt <= busy_cnt + 1;
            if (bus.start && !bus.busy) start_cyc <= cyc_ctr;
            if (prev_stall && (!bus.dout_valid || bus.dout !== prev_dout)) stab_err <= stab_err + 1;
            prev_stall <= bus.dout_valid && !bus.dout_ready;
            prev_dout  <= bus.dout;
        end
    end

    function automatic logic [31:0] exp_word(input int i, input int len);
        logic [31:0] x;
        int nw, rem;
        x   = din_a[i] ^ ks_a[i];
        nw  = (len + 31) / 32;
        rem = len % 32;
`ifdef SNOW3G_TAIL_MASK_EN
        if (i == nw - 1 && rem != 0) begin
            for (int b = 0; b < 32 - rem; b++) x[b] = 1'b0;
        end
`endif
        return x;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 64; i++) begin
            ks_a[i]  = $urandom;
            din_a[i] = $urandom;
        end
    endtask

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.ks_valid   = 1'b0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
    endtask

    // Drive one message. mode: 0 ready always, 1 ready toggles, 2 random
    // ready and din gaps. ks_valid drops for 3 cycles from stall_at.
    // stop_words > 0 abandons the message once that many words came out.
    // A second start is pulsed at cycle restart_at.
    task automatic run_msg(input int len, input int mode, input int stall_at,
                           input int stop_words, input int restart_at);
        int nw, cyc, k, d, post, occ;
        nw = (len + 31) / 32;
        ks_base = ks_hs; din_base = din_hs; got_base = got_q.size();
        done_base = done_cnt; busy_base = busy_cnt; stab_base = stab_err;
        max_occ = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.len_bits = len[15:0];
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        post = 0;
        while (cyc < 2000 && post < 3) begin
            k = ks_hs - ks_base;
            d = din_hs - din_base;
            occ = k - d;
            if (occ > max_occ) max_occ = occ;
            bus.ks_valid   = !(cyc >= stall_at && cyc < stall_at + 3);
            bus.ks_word    = ks_a[k & 63];
            bus.din_valid  = (d < nw) && ((mode != 2) || ($urandom_range(0, 3) != 0));
            bus.din        = din_a[d & 63];
            bus.dout_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc[0] == 1'b0) : ($urandom_range(0, 1) == 1);
            bus.start      = (cyc == restart_at);
            if (cyc == restart_at) bus.len_bits = 16'd32;
            if (stop_words > 0 && (got_q.size() - got_base) >= stop_words) break;
            if (done_cnt != done_base) post++;
            @(negedge clk);
            cyc++;
        end
        if (stop_words == 0) idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.ks_valid  = 1'b1;
        bus.din_valid = 1'b1;
        bus.len_bits  = 16'd64;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.ks_ready, bus.din_ready, bus.dout_valid, bus.dout_last} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=000000",
                     {bus.busy, bus.done, bus.ks_ready, bus.din_ready, bus.dout_valid, bus.dout_last});
        end
        total++;
        if (bus.dout !== 32'd0) begin
            bad++;
            $display("FAIL reset_dout got=%h want=00000000", bus.dout);
        end
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        total++;
        if ({bus.busy, bus.ks_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle got=%b want=00", {bus.busy, bus.ks_ready});
        end
    endtask

    task automatic test_vector64();
        ks_a[0] = 32'hFFFFFFFF; ks_a[1] = 32'h0F0F0F0F;
        din_a[0] = 32'h12345678; din_a[1] = 32'hAAAAAAAA;
        run_msg(64, 0, -10, 0, -1);
        total++;
        if (got_q.size() - got_base !== 2) begin
            bad++;
            $display("FAIL v64_count got=%0d want=2", got_q.size() - got_base);
        end else begin
            total++;
            if (got_q[got_base] !== 32'hEDCBA987) begin
                bad++;
                $display("FAIL v64_word0 got=%h want=EDCBA987", got_q[got_base]);
            end
            total++;
            if (got_q[got_base + 1] !== 32'hA5A5A5A5) begin
                bad++;
                $display("FAIL v64_word1 got=%h want=A5A5A5A5", got_q[got_base + 1]);
            end
            total++;
            if ({got_last_q[got_base], got_last_q[got_base + 1]} !== 2'b01) begin
                bad++;
                $display("FAIL v64_last got=%b want=01", {got_last_q[got_base], got_last_q[got_base + 1]});
            end
        end
        total++;
        if (ks_hs - ks_base !== 2) begin
            bad++;
            $display("FAIL v64_ks_hs got=%0d want=2", ks_hs - ks_base);
        end
        total++;
        if (done_cnt - done_base !== 1 || done_cyc !== last_cyc + 1) begin
            bad++;
            $display("FAIL v64_done count=%0d want=1 delay=%0d want=1", done_cnt - done_base, done_cyc - last_cyc);
        end
    endtask

    task automatic test_tail40();
        logic [31:0] want1;
`ifdef SNOW3G_TAIL_MASK_EN
        want1 = 32'hFF000000;
`else
        want1 = 32'hFFFFFFFF;
`endif
        ks_a[0] = 32'h00000000; ks_a[1] = 32'hFFFFFFFF;
        din_a[0] = 32'h00000000; din_a[1] = 32'h00000000;
        run_msg(40, 0, -10, 0, -1);
        total++;
        if (got_q.size() - got_base !== 2) begin
            bad++;
            $display("FAIL t40_count got=%0d want=2", got_q.size() - got_base);
        end else begin
            total++;
            if (got_q[got_base + 1] !== want1 || got_q[got_base] !== 32'd0) begin
                bad++;
                $display("FAIL t40_words got=%h,%h want=00000000,%h", got_q[got_base], got_q[got_base + 1], want1);
            end
        end
    endtask

    task automatic test_len0();
        bus.ks_valid = 1'b1;
        bus.din_valid = 1'b1;
        run_msg(0, 0, -10, 0, -1);
        total++;
        if ((ks_hs - ks_base) !== 0 || (din_hs - din_base) !== 0 || (got_q.size() - got_base) !== 0) begin
            bad++;
            $display("FAIL len0_traffic ks=%0d din=%0d dout=%0d want=0,0,0",
                     ks_hs - ks_base, din_hs - din_base, got_q.size() - got_base);
        end
        total++;
        if (done_cnt - done_base !== 1 || busy_cnt - busy_base !== 1) begin
            bad++;
            $display("FAIL len0_done done=%0d busy=%0d want=1,1", done_cnt - done_base, busy_cnt - busy_base);
        end
        total++;
        if (done_cyc - start_cyc < 1 || done_cyc - start_cyc > 2) begin
            bad++;
            $display("FAIL len0_delay got=%0d want=1..2", done_cyc - start_cyc);
        end
    endtask

    // Full check of one completed message against the model
    task automatic test_stream(input string name, input int len, input int mode, input int stall_at);
        int nw, n;
        nw = (len + 31) / 32;
        fill_random();
        run_msg(len, mode, stall_at, 0, -1);
        n = got_q.size() - got_base;
        total++;
        if (n !== nw) begin
            bad++;
            $display("FAIL %s_count got=%0d want=%0d", name, n, nw);
        end
        for (int i = 0; i < nw && i < n; i++) begin
            total++;
            if (got_q[got_base + i] !== exp_word(i, len) || got_last_q[got_base + i] !== (i == nw - 1)) begin
                bad++;
                $display("FAIL %s_word%0d got=%h/%b want=%h/%b", name, i, got_q[got_base + i],
                         got_last_q[got_base + i], exp_word(i, len), (i == nw - 1));
            end
        end
        total++;
        if (ks_hs - ks_base !== nw || done_cnt - done_base !== 1) begin
            bad++;
            $display("FAIL %s_hs ks=%0d done=%0d want=%0d,1", name, ks_hs - ks_base, done_cnt - done_base, nw);
        end
        total++;
        if (stab_err !== stab_base || max_occ > 4) begin
            bad++;
            $display("FAIL %s_flow unstable=%0d occ=%0d want=0,<=4", name, stab_err - stab_base, max_occ);
        end
    endtask

    task automatic test_midreset();
        fill_random();
        run_msg(256, 0, -10, 3, -1);
        total++;
        if (got_q.size() - got_base < 3) begin
            bad++;
            $display("FAIL mrst_progress got=%0d want=3", got_q.size() - got_base);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.ks_ready, bus.din_ready, bus.dout_valid, bus.dout_last} !== 6'b0
            || bus.dout !== 32'd0) begin
            bad++;
            $display("FAIL mrst_outputs got=%b/%h want=000000/00000000",
                     {bus.busy, bus.done, bus.ks_ready, bus.din_ready, bus.dout_valid, bus.dout_last}, bus.dout);
        end
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        fill_random();
        run_msg(32, 0, -10, 0, -1);
        total++;
        if (got_q.size() - got_base !== 1 || ks_hs - ks_base !== 1) begin
            bad++;
            $display("FAIL mrst_count dout=%0d ks=%0d want=1,1", got_q.size() - got_base, ks_hs - ks_base);
        end else begin
            total++;
            if (got_q[got_base] !== exp_word(0, 32) || got_last_q[got_base] !== 1'b1) begin
                bad++;
                $display("FAIL mrst_word got=%h/%b want=%h/1", got_q[got_base], got_last_q[got_base], exp_word(0, 32));
            end
        end
    endtask

    task automatic test_start_busy();
        int n;
        fill_random();
        run_msg(128, 0, -10, 0, 3);
        n = got_q.size() - got_base;
        total++;
        if (n !== 4 || done_cnt - done_base !== 1 || ks_hs - ks_base !== 4) begin
            bad++;
            $display("FAIL restart_count dout=%0d done=%0d ks=%0d want=4,1,4", n, done_cnt - done_base, ks_hs - ks_base);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            total++;
            if (got_q[got_base + i] !== exp_word(i, 128)) begin
                bad++;
                $display("FAIL restart_word%0d got=%h want=%h", i, got_q[got_base + i], exp_word(i, 128));
            end
        end
    endtask

    initial begin
        idle_inputs();
        bus.len_bits = 16'd0;
        bus.ks_word  = 32'd0;
        bus.din      = 32'd0;
        test_reset();
        test_vector64();
        test_tail40();
        test_len0();
        test_stream("stall256", 256, 1, 2);
        test_midreset();
        test_start_busy();
        for (int r = 0; r < 3; r++) begin
            test_stream("random", $urandom_range(1, 1024), 2, $urandom_range(0, 10));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
